lcd_cmd_sequencer: RTL

//  HD44780-class character-LCD controller: runs the power-on init sequence, then serialises

---
 rtl/lcd_cmd_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lcd_cmd_sequencer.sv
// HD44780-class LCD write sequencer: power-on init from a small ROM, then single-byte
// command/character transfers with all bus timing derived from one shared cycle counter.
module lcd_cmd_sequencer #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EPULSE  = 12,
  parameter int T_CMD     = 2100,
  parameter int T_CLEAR   = 82000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam logic [22:0] L_POWERUP = 23'(T_POWERUP - 1);
  localparam logic [22:0] L_SETUP   = 23'(T_SETUP - 1);
  localparam logic [22:0] L_EPULSE  = 23'(T_EPULSE - 1);
  localparam logic [22:0] L_CMD     = 23'(T_CMD - 1);
  localparam logic [22:0] L_CLEAR   = 23'(T_CLEAR - 1);
  localparam logic [22:0] L_INIT1   = 23'(T_INIT1 - 1);
  localparam logic [22:0] L_INIT2   = 23'(T_INIT2 - 1);
  localparam logic [2:0]  LAST_STEP = 3'd6;

  typedef enum logic [2:0] {PWR_WAIT, SETUP, E_HIGH, HOLD, IDLE} state_t;

  state_t      state_q, state_d;
  logic [22:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        init_done_q, init_done_d;

  function automatic logic [7:0] rom_byte(input logic [2:0] step);
    case (step)
      3'd4:    rom_byte = 8'h0C;
      3'd5:    rom_byte = 8'h01;
      3'd6:    rom_byte = 8'h06;
      default: rom_byte = 8'h38;
    endcase
  endfunction

  function automatic logic [22:0] rom_wait(input logic [2:0] step);
    case (step)
      3'd0:    rom_wait = L_INIT1;
      3'd1:    rom_wait = L_INIT2;
      3'd5:    rom_wait = L_CLEAR;
      default: rom_wait = L_CMD;
    endcase
  endfunction

  // Clear/home commands need the long execution wait.
  function automatic logic [22:0] req_wait(input logic rs, input logic [7:0] data);
    if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) req_wait = L_CLEAR;
    else                                                          req_wait = L_CMD;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  // PWR_WAIT counts up from the reset value of 0; every other state loads N-1 and counts down.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == L_POWERUP) begin
          state_d = SETUP;
          cnt_d   = L_SETUP;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          data_d  = rom_byte(3'd0);
        end else begin
          cnt_d = cnt_q + 23'd1;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = E_HIGH;
          cnt_d   = L_EPULSE;
        end else begin
          cnt_d = cnt_q - 23'd1;
        end
      end
      E_HIGH: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = init_done_q ? req_wait(rs_q, data_q) : rom_wait(idx_q);
        end else begin
          cnt_d = cnt_q - 23'd1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 23'd1;
        end else if (!init_done_q && idx_q != LAST_STEP) begin
          state_d = SETUP;
          cnt_d   = L_SETUP;
          idx_d   = idx_q + 3'd1;
          rs_d    = 1'b0;
          data_d  = rom_byte(idx_q + 3'd1);
        end else begin
          state_d     = IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cnt_d   = L_SETUP;
          rs_d    = req_rs;
          data_d  = req_data;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign init_done = init_done_q;
  assign LCD_E     = (state_q == E_HIGH);
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign LCD_DATA  = data_q;

endmodule
